// File: rtl/d5m_stream_ctrl.sv
// d5m_stream_ctrl: D5M camera pixel bus to AXI4-Stream video master through a pixel FIFO.
// Define D5M_TESTPATTERN_EN to allow replacing camera pixels with a coordinate test pattern.
module d5m_stream_ctrl #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int CORD_W     = 12
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              iEnable,
  input  logic              iImageTypeTest,
  input  logic              iClrOverflow,
  input  logic              ifvalid,
  input  logic              ilvalid,
  input  logic [DATA_W-1:0] iRgb,
  input  logic              rgb_m_axis_tready,
  output logic              rgb_m_axis_tvalid,
  output logic              rgb_m_axis_tuser,
  output logic              rgb_m_axis_tlast,
  output logic [DATA_W-1:0] rgb_m_axis_tdata,
  output logic [CORD_W-1:0] xCord,
  output logic [CORD_W-1:0] yCord,
  output logic              endOfFrame,
  output logic              oOverflow,
  output logic              oBusy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, SYNC, WAIT_SOF, ACTIVE, ENDF} state_t;
  state_t state;
  logic hold_v, hold_u, first, line_start;
  logic [DATA_W-1:0] hold_d, pix;
  logic [CORD_W-1:0] px;
  logic sof, act, take, flush, push, pop, full, wr;
  logic [AW:0] wp, rp;
  logic [DATA_W+1:0] mem [FIFO_DEPTH];
  assign sof   = state == WAIT_SOF && iEnable && ifvalid;
  assign act   = state == ACTIVE;
  assign take  = (sof || act) && ifvalid && ilvalid;
  assign flush = act && hold_v && !(ifvalid && ilvalid);
  assign push  = hold_v && (take || flush);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = rgb_m_axis_tvalid && rgb_m_axis_tready;
  assign wr    = push && (!full || pop);
  assign px    = (line_start || sof) ? '0 : (&xCord ? xCord : xCord + 1'b1);
  assign rgb_m_axis_tvalid = wp != rp;
  assign {rgb_m_axis_tuser, rgb_m_axis_tlast, rgb_m_axis_tdata} =
    rgb_m_axis_tvalid ? mem[rp[AW-1:0]] : '0;
`ifdef D5M_TESTPATTERN_EN
  logic tp_sel, tp_now;
  logic [CORD_W-1:0] py;
  assign py     = sof ? '0 : yCord;
  assign tp_now = sof ? iImageTypeTest : tp_sel;
  assign pix    = tp_now ? DATA_W'({px[7:0], py[7:0], px[7:0] ^ py[7:0]}) : iRgb;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) tp_sel <= 1'b0;
    else tp_sel <= tp_now;
`else
  logic unused_tp;
  assign unused_tp = iImageTypeTest;
  assign pix       = iRgb;
`endif
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state      <= IDLE;
      oBusy      <= 1'b0;
      endOfFrame <= 1'b0;
    end else begin
      endOfFrame <= 1'b0;
      case (state)
        IDLE:     if (iEnable) begin state <= SYNC; oBusy <= 1'b1; end
        SYNC:     if (!ifvalid) state <= WAIT_SOF;
        WAIT_SOF: if (!iEnable) begin state <= IDLE; oBusy <= 1'b0; end
                  else if (ifvalid) state <= ACTIVE;
        ACTIVE:   if (!ifvalid) begin state <= ENDF; endOfFrame <= 1'b1; end
        default:  begin state <= iEnable ? WAIT_SOF : IDLE; oBusy <= iEnable; end
      endcase
    end
  // one-pixel hold delays each push so the last pixel of a line can carry tlast
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      hold_v     <= 1'b0;
      hold_u     <= 1'b0;
      hold_d     <= '0;
      first      <= 1'b0;
      line_start <= 1'b0;
      xCord      <= '0;
      yCord      <= '0;
      wp         <= '0;
      rp         <= '0;
      oOverflow  <= 1'b0;
    end else begin
      hold_v <= take || (hold_v && !flush);
      if (take) begin
        hold_d <= pix;
        hold_u <= first || sof;
        xCord  <= px;
      end
      first      <= !take && (sof || first);
      line_start <= !take && (sof || flush || line_start);
      yCord      <= sof ? '0 : (flush ? yCord + 1'b1 : yCord);
      wp         <= wr ? wp + 1'b1 : wp;
      rp         <= pop ? rp + 1'b1 : rp;
      oOverflow  <= (push && !wr) || (!iClrOverflow && oOverflow);
    end
  always_ff @(posedge ACLK)
    if (wr) mem[wp[AW-1:0]] <= {hold_u, flush, hold_d};
endmodule

// File: tb/tb_d5m_stream_ctrl.sv
// tb_d5m_stream_ctrl: directed vector bench for d5m_stream_ctrl.
module tb_d5m_stream_ctrl;
  logic ACLK = 1'b0, ARESETN = 1'b0;
  logic iEnable = 1'b0, iImageTypeTest = 1'b0, iClrOverflow = 1'b0;
  logic ifvalid = 1'b0, ilvalid = 1'b0, rgb_m_axis_tready = 1'b1;
  logic [23:0] iRgb = '0;
  logic rgb_m_axis_tvalid, rgb_m_axis_tuser, rgb_m_axis_tlast;
  logic [23:0] rgb_m_axis_tdata;
  logic [11:0] xCord, yCord;
  logic endOfFrame, oOverflow, oBusy;
  int nvec = 0, nerr = 0;

  typedef struct packed {logic u, l; logic [23:0] d;} beat_t;
  typedef struct packed {
    logic en, fv, lv; logic [23:0] rgb;
    logic tv, tu, tl; logic [23:0] td; logic eof, busy; logic [11:0] x, y;
  } vec_t;
  beat_t beats[$], exp_q[$];
  vec_t tbl[16];
`ifdef D5M_TESTPATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  d5m_stream_ctrl dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .iEnable(iEnable), .iImageTypeTest(iImageTypeTest),
    .iClrOverflow(iClrOverflow), .ifvalid(ifvalid), .ilvalid(ilvalid), .iRgb(iRgb),
    .rgb_m_axis_tready(rgb_m_axis_tready), .rgb_m_axis_tvalid(rgb_m_axis_tvalid),
    .rgb_m_axis_tuser(rgb_m_axis_tuser), .rgb_m_axis_tlast(rgb_m_axis_tlast),
    .rgb_m_axis_tdata(rgb_m_axis_tdata), .xCord(xCord), .yCord(yCord),
    .endOfFrame(endOfFrame), .oOverflow(oOverflow), .oBusy(oBusy)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK)
    if (ARESETN && rgb_m_axis_tvalid && rgb_m_axis_tready)
      beats.push_back({rgb_m_axis_tuser, rgb_m_axis_tlast, rgb_m_axis_tdata});

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input logic fv, input logic lv, input logic [23:0] rgb);
    ifvalid = fv; ilvalid = lv; iRgb = rgb;
    @(posedge ACLK); #1;
  endtask

  task automatic frame(input int w, input int h, input logic [23:0] base, input int en_off);
    int k;
    k = 0;
    step(1, 0, 0);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (k == en_off) iEnable = 1'b0;
        step(1, 1, base + 24'(k));
        k++;
      end
      step(1, 0, 0);
    end
    repeat (4) step(0, 0, 0);
  endtask

  task automatic expect_frame(input int w, input int h, input logic [23:0] base, input bit tp);
    logic [7:0] x, y;
    exp_q.delete();
    for (int k = 0; k < w * h; k++) begin
      x = 8'(k % w);
      y = 8'(k / w);
      exp_q.push_back({k == 0, (k % w) == w - 1, tp ? {x, y, x ^ y} : base + 24'(k)});
    end
  endtask

  task automatic check_beats(input string nm);
    chk({nm, " beat count"}, 64'(beats.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
      chk($sformatf("%s beat%0d", nm, i), 64'(beats[i]), 64'(exp_q[i]));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({rgb_m_axis_tvalid, rgb_m_axis_tuser, rgb_m_axis_tlast, rgb_m_axis_tdata,
                endOfFrame, oOverflow, oBusy, xCord, yCord});
  endfunction

  initial begin
    //           en fv lv rgb  tv tu tl td  eof busy x y
    tbl[0]  = '{1, 0, 0, 0,   0, 0, 0, 0,  0, 1, 0, 0};
    tbl[1]  = '{1, 0, 0, 0,   0, 0, 0, 0,  0, 1, 0, 0};
    tbl[2]  = '{1, 0, 0, 0,   0, 0, 0, 0,  0, 1, 0, 0};
    tbl[3]  = '{1, 1, 0, 0,   0, 0, 0, 0,  0, 1, 0, 0};
    tbl[4]  = '{1, 1, 1, 1,   0, 0, 0, 0,  0, 1, 0, 0};
    tbl[5]  = '{1, 1, 1, 2,   1, 1, 0, 1,  0, 1, 1, 0};
    tbl[6]  = '{1, 1, 1, 3,   1, 0, 0, 2,  0, 1, 2, 0};
    tbl[7]  = '{1, 1, 1, 4,   1, 0, 0, 3,  0, 1, 3, 0};
    tbl[8]  = '{1, 1, 0, 0,   1, 0, 1, 4,  0, 1, 3, 1};
    tbl[9]  = '{1, 1, 1, 5,   0, 0, 0, 0,  0, 1, 0, 1};
    tbl[10] = '{1, 1, 1, 6,   1, 0, 0, 5,  0, 1, 1, 1};
    tbl[11] = '{1, 1, 1, 7,   1, 0, 0, 6,  0, 1, 2, 1};
    tbl[12] = '{1, 1, 1, 8,   1, 0, 0, 7,  0, 1, 3, 1};
    tbl[13] = '{1, 1, 0, 0,   1, 0, 1, 8,  0, 1, 3, 2};
    tbl[14] = '{1, 0, 0, 0,   0, 0, 0, 0,  1, 1, 3, 2};
    tbl[15] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 3, 2};

    repeat (2) step(0, 0, 0);
    chk("reset outputs", all_outs(), 64'd0);
    ARESETN = 1'b1;
    step(0, 0, 0);
    chk("idle after reset", all_outs(), 64'd0);

    for (int i = 0; i < 16; i++) begin
      iEnable = tbl[i].en;
      step(tbl[i].fv, tbl[i].lv, tbl[i].rgb);
      chk($sformatf("frame4x2 cyc%0d", i),
          64'({rgb_m_axis_tvalid, rgb_m_axis_tuser, rgb_m_axis_tlast, rgb_m_axis_tdata,
               endOfFrame, oBusy, xCord, yCord}),
          64'({tbl[i].tv, tbl[i].tu, tbl[i].tl, tbl[i].td, tbl[i].eof, tbl[i].busy,
               tbl[i].x, tbl[i].y}));
    end

    // enable raised mid-frame: that frame is skipped, the next one is captured whole
    beats.delete();
    step(1, 0, 0);
    step(1, 1, 24'h100);
    step(1, 1, 24'h101);
    iEnable = 1'b1;
    step(1, 1, 24'h102);
    step(1, 1, 24'h103);
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 24'h104 + 24'(i));
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    chk("midframe enable no output", 64'(beats.size()), 64'd0);
    expect_frame(4, 2, 24'h11, 1'b0);
    frame(4, 2, 24'h11, -1);
    check_beats("midframe enable");

    beats.delete();
    iImageTypeTest = 1'b1;
    expect_frame(4, 2, 24'h30, TP);
    frame(4, 2, 24'h30, -1);
    iImageTypeTest = 1'b0;
    check_beats("image type test");

    // 40-pixel line into a stalled sink; sink wakes on the line-end cycle
    beats.delete();
    rgb_m_axis_tready = 1'b0;
    step(1, 0, 0);
    for (int i = 1; i <= 40; i++) step(1, 1, 24'h100 + 24'(i));
    chk("overflow set", 64'(oOverflow), 64'd1);
    chk("stall holds beat", 64'({rgb_m_axis_tvalid, rgb_m_axis_tuser, rgb_m_axis_tlast, rgb_m_axis_tdata}),
        64'({3'b110, 24'h101}));
    rgb_m_axis_tready = 1'b1;
    step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    exp_q.delete();
    for (int i = 1; i <= 16; i++) exp_q.push_back({i == 1, 1'b0, 24'h100 + 24'(i)});
    exp_q.push_back({1'b0, 1'b1, 24'h128});
    check_beats("overflow");
    chk("overflow sticky", 64'(oOverflow), 64'd1);
    iClrOverflow = 1'b1;
    step(0, 0, 0);
    iClrOverflow = 1'b0;
    chk("overflow cleared", 64'(oOverflow), 64'd0);

    beats.delete();
    expect_frame(4, 3, 24'h40, 1'b0);
    frame(4, 3, 24'h40, 1);
    check_beats("enable drop");
    chk("idle after enable drop", 64'(oBusy), 64'd0);

    // reset in line 2 with data still buffered
    beats.delete();
    iEnable = 1'b1;
    repeat (2) step(0, 0, 0);
    rgb_m_axis_tready = 1'b0;
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 24'h50 + 24'(i));
    step(1, 0, 0);
    step(1, 1, 24'h54);
    step(1, 1, 24'h55);
    ARESETN = 1'b0;
    #2;
    chk("reset mid-frame outputs", all_outs(), 64'd0);
    rgb_m_axis_tready = 1'b1;
    step(1, 1, 24'h56);
    ARESETN = 1'b1;
    step(1, 1, 24'h57);
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 24'h58 + 24'(i));
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    expect_frame(4, 2, 24'h60, 1'b0);
    frame(4, 2, 24'h60, -1);
    check_beats("after reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
